// File: rtl/gate_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl_pkg : state encodings and gate truth tables
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit i of each table is the gate result for input vector i.
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_XOR2 = 4'b0110;
  localparam logic [1:0] TT_NOT1 = 2'b01;

endpackage

`default_nettype wire

// File: rtl/gate_sweep_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : clearable up-counter that sticks at all-ones
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {WIDTH{1'b1}})) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl : sweeps all input vectors of a small gate and checks its output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int                 N_IN   = 2,
  parameter int                 HOLD   = 2,
  parameter logic [2**N_IN-1:0] EXPECT = TT_AND2,
  parameter int                 ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  gate_in,
  input  logic             gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             fail_seen
);

  localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

  state_e          state_q,      state_d;
  logic [N_IN-1:0] vec_q,        vec_d;
  logic [7:0]      hold_cnt_q,   hold_cnt_d;
  logic [N_IN-1:0] gate_in_q,    gate_in_d;
  logic            busy_q,       busy_d;
  logic            done_q,       done_d;
  logic            pass_q,       pass_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic            fail_seen_q,  fail_seen_d;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            compare_cycle;
  logic            mismatch;

  assign compare_cycle = (hold_cnt_q == HOLD_LAST);
  assign mismatch      = (gate_out != EXPECT[vec_q]);

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_cnt_d   = hold_cnt_q;
    gate_in_d    = gate_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gate_in_d = '0;
        busy_d    = 1'b0;
        if (start) begin
          state_d      = ST_DRIVE;
          busy_d       = 1'b1;
          vec_d        = '0;
          hold_cnt_d   = '0;
          pass_d       = 1'b0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          cnt_clr      = 1'b1;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          // Any compare in this cycle is dropped; partial results stay visible.
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          gate_in_d = '0;
        end else if (compare_cycle) begin
          if (mismatch) begin
            cnt_inc = 1'b1;
            if (!fail_seen_q) begin
              first_fail_d = vec_q;
              fail_seen_d  = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            pass_d    = ~(fail_seen_q | mismatch);
            busy_d    = 1'b0;
            gate_in_d = '0;
          end else begin
            vec_d      = vec_q + N_IN'(1);
            hold_cnt_d = '0;
            gate_in_d  = vec_q + N_IN'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        gate_in_d = '0;
      end

      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        gate_in_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      hold_cnt_q   <= '0;
      gate_in_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_cnt_q   <= hold_cnt_d;
      gate_in_q    <= gate_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (err_cnt)
  );

  assign gate_in    = gate_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_ctrl : directed checks of gate_sweep_ctrl on three configurations
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_ctrl;
  import gate_sweep_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  // A: AND cell, AND table, HOLD=2
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic [1:0] gate_in_a;
  logic       gate_out_a, busy_a, done_a, pass_a, fs_a;
  logic [7:0] err_a;
  logic [1:0] ff_a;
  // B: AND cell, OR table, HOLD=1
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [1:0] gate_in_b;
  logic       gate_out_b, busy_b, done_b, pass_b, fs_b;
  logic [7:0] err_b;
  logic [1:0] ff_b;
  // C: output forced to inverse of AND table, ERR_W=1
  logic       start_c = 1'b0, abort_c = 1'b0;
  logic [1:0] gate_in_c;
  logic       gate_out_c, busy_c, done_c, pass_c, fs_c;
  logic [0:0] err_c;
  logic [1:0] ff_c;
  logic [3:0] tt_c = 4'b1000;

  assign gate_out_a = gate_in_a[1] & gate_in_a[0];
  assign gate_out_b = gate_in_b[1] & gate_in_b[0];
  assign gate_out_c = ~tt_c[gate_in_c];

  gate_sweep_ctrl #(.N_IN(2), .HOLD(2), .EXPECT(TT_AND2), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .gate_in(gate_in_a),
    .gate_out(gate_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_fail(ff_a), .fail_seen(fs_a));

  gate_sweep_ctrl #(.N_IN(2), .HOLD(1), .EXPECT(TT_OR2), .ERR_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .gate_in(gate_in_b),
    .gate_out(gate_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_fail(ff_b), .fail_seen(fs_b));

  gate_sweep_ctrl #(.N_IN(2), .HOLD(2), .EXPECT(TT_AND2), .ERR_W(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .gate_in(gate_in_c),
    .gate_out(gate_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_c), .first_fail(ff_c), .fail_seen(fs_c));

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gate_in_a !== 2'b00) $display("FAIL reset gate_in: got %b want 00", gate_in_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL reset busy: got %b want 0", busy_a); else passed++;
    checks++; if (done_a !== 1'b0) $display("FAIL reset done: got %b want 0", done_a); else passed++;
    checks++; if (pass_a !== 1'b0) $display("FAIL reset pass: got %b want 0", pass_a); else passed++;
    checks++; if (err_a !== 8'd0) $display("FAIL reset err_cnt: got %0d want 0", err_a); else passed++;
    checks++; if (ff_a !== 2'b00) $display("FAIL reset first_fail: got %b want 00", ff_a); else passed++;
    checks++; if (fs_a !== 1'b0) $display("FAIL reset fail_seen: got %b want 0", fs_a); else passed++;
    checks++; if (err_c !== 1'b0) $display("FAIL reset err_cnt_c: got %b want 0", err_c); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_and_sweep();
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (k <= 8) begin
        checks++; if (gate_in_a !== 2'((k - 1) / 2)) $display("FAIL and gate_in k=%0d: got %b want %b", k, gate_in_a, 2'((k - 1) / 2)); else passed++;
        checks++; if (busy_a !== 1'b1) $display("FAIL and busy k=%0d: got %b want 1", k, busy_a); else passed++;
      end else if (k == 9) begin
        checks++; if (done_a !== 1'b1) $display("FAIL and done: got %b want 1", done_a); else passed++;
        checks++; if (pass_a !== 1'b1) $display("FAIL and pass: got %b want 1", pass_a); else passed++;
        checks++; if (err_a !== 8'd0) $display("FAIL and err_cnt: got %0d want 0", err_a); else passed++;
        checks++; if (fs_a !== 1'b0) $display("FAIL and fail_seen: got %b want 0", fs_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL and busy_done: got %b want 0", busy_a); else passed++;
      end else begin
        checks++; if (done_a !== 1'b0) $display("FAIL and done_after: got %b want 0", done_a); else passed++;
        checks++; if (pass_a !== 1'b1) $display("FAIL and pass_hold: got %b want 1", pass_a); else passed++;
      end
    end
  endtask

  task automatic test_or_table();
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (k <= 4) begin
        checks++; if (gate_in_b !== 2'(k - 1)) $display("FAIL or gate_in k=%0d: got %b want %b", k, gate_in_b, 2'(k - 1)); else passed++;
      end else begin
        checks++; if (done_b !== 1'b1) $display("FAIL or done: got %b want 1", done_b); else passed++;
        checks++; if (err_b !== 8'd2) $display("FAIL or err_cnt: got %0d want 2", err_b); else passed++;
        checks++; if (ff_b !== 2'b01) $display("FAIL or first_fail: got %b want 01", ff_b); else passed++;
        checks++; if (fs_b !== 1'b1) $display("FAIL or fail_seen: got %b want 1", fs_b); else passed++;
        checks++; if (pass_b !== 1'b0) $display("FAIL or pass: got %b want 0", pass_b); else passed++;
      end
    end
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a === 1'b1) done_seen++;
      if (k == 5) begin
        abort_a = 1'b0;
        checks++; if (gate_in_a !== 2'b00) $display("FAIL abort gate_in: got %b want 00", gate_in_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL abort busy: got %b want 0", busy_a); else passed++;
      end
      if (k == 4) abort_a = 1'b1;
    end
    checks++; if (done_seen !== 0) $display("FAIL abort done_pulses: got %0d want 0", done_seen); else passed++;
    checks++; if (pass_a !== 1'b0) $display("FAIL abort pass: got %b want 0", pass_a); else passed++;

    // Abort on a compare cycle of B after one mismatch: second mismatch is dropped.
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (k == 4) begin
        abort_b = 1'b0;
        checks++; if (busy_b !== 1'b0) $display("FAIL abort_b busy: got %b want 0", busy_b); else passed++;
      end
      if (k == 3) abort_b = 1'b1;
    end
    checks++; if (err_b !== 8'd1) $display("FAIL abort_b err_cnt: got %0d want 1", err_b); else passed++;
    checks++; if (ff_b !== 2'b01) $display("FAIL abort_b first_fail: got %b want 01", ff_b); else passed++;
    checks++; if (fs_b !== 1'b1) $display("FAIL abort_b fail_seen: got %b want 1", fs_b); else passed++;
    checks++; if (done_b !== 1'b0) $display("FAIL abort_b done: got %b want 0", done_b); else passed++;

    // start and abort together in IDLE: start wins; held abort then cancels.
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) $display("FAIL start_abort busy: got %b want 1", busy_a); else passed++;
    @(negedge clk);
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) $display("FAIL start_abort cancel busy: got %b want 0", busy_a); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++; if (done_a !== ((k == 9) || (k == 19))) $display("FAIL b2b done k=%0d: got %b want %b", k, done_a, ((k == 9) || (k == 19))); else passed++;
      if (k <= 8) begin
        checks++; if (gate_in_a !== 2'((k - 1) / 2)) $display("FAIL b2b gate_in k=%0d: got %b want %b", k, gate_in_a, 2'((k - 1) / 2)); else passed++;
      end
      if (k == 9) begin
        checks++; if (pass_a !== 1'b1) $display("FAIL b2b pass: got %b want 1", pass_a); else passed++;
        checks++; if (err_a !== 8'd0) $display("FAIL b2b err_cnt: got %0d want 0", err_a); else passed++;
      end
      if (k == 20) begin
        checks++; if (pass_a !== 1'b1) $display("FAIL b2b pass2: got %b want 1", pass_a); else passed++;
        checks++; if (fs_a !== 1'b0) $display("FAIL b2b fail_seen2: got %b want 0", fs_a); else passed++;
      end
      start_a = (k == 3) || (k == 9) || (k == 10);
    end
    start_a = 1'b0;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    start_c = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (k == 9) begin
        checks++; if (done_c !== 1'b1) $display("FAIL sat done: got %b want 1", done_c); else passed++;
        checks++; if (err_c !== 1'b1) $display("FAIL sat err_cnt: got %b want 1", err_c); else passed++;
        checks++; if (ff_c !== 2'b00) $display("FAIL sat first_fail: got %b want 00", ff_c); else passed++;
        checks++; if (fs_c !== 1'b1) $display("FAIL sat fail_seen: got %b want 1", fs_c); else passed++;
        checks++; if (pass_c !== 1'b0) $display("FAIL sat pass: got %b want 0", pass_c); else passed++;
      end
    end
  endtask

  task automatic test_rst_mid();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (k >= 6 && done_a === 1'b1) done_seen++;
      if (k == 6) begin
        rst = 1'b0;
        checks++; if (gate_in_a !== 2'b00) $display("FAIL rst_mid gate_in: got %b want 00", gate_in_a); else passed++;
        checks++; if (busy_a !== 1'b0) $display("FAIL rst_mid busy: got %b want 0", busy_a); else passed++;
        checks++; if (pass_a !== 1'b0) $display("FAIL rst_mid pass: got %b want 0", pass_a); else passed++;
        checks++; if (err_a !== 8'd0) $display("FAIL rst_mid err_cnt: got %0d want 0", err_a); else passed++;
        checks++; if (ff_a !== 2'b00) $display("FAIL rst_mid first_fail: got %b want 00", ff_a); else passed++;
        checks++; if (fs_a !== 1'b0) $display("FAIL rst_mid fail_seen: got %b want 0", fs_a); else passed++;
      end
      if (k == 5) rst = 1'b1;
    end
    checks++; if (done_seen !== 0) $display("FAIL rst_mid done_pulses: got %0d want 0", done_seen); else passed++;
    test_and_sweep();
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_or_table();
    test_abort();
    test_back_to_back();
    test_saturate();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
